matrix_bcd_loader: RTL
======================

// Module: matrix_bcd_loader
// PURPOSE
//  Upstream feeder for the VGA matrix text overlay. Accepts binary matrix-element writes, converts each
//  value to DIGITS BCD digits (iterative double-dabble), stores them in a shadow buffer, and copies the
//  shadow to the display buffer on each vblank rising edge (tear-free). bcd_flat drives the digit_8x16
//  bcd inputs.
// PARAMETERS
//  MATRIX_N  3   rows per matrix
//  MATRIX_M  3   columns per matrix
//  NUM_MAT   3   matrices shown side by side (A, B, result)
//  DIGITS    5   BCD digits per element
//  VALUE_W   16  width of unsigned input value
//  LZ_BLANK  1   1: leading zeros shown as code 4'hA (blank glyph); least-significant digit always shown
// PORTS
//  clk       in   1                        system clock (same clock as the VGA counters)
//  reset_n   in   1                        asynchronous active-low reset
//  wr_valid  in   1                        element write request
//  wr_ready  out  1                        loader can accept a write
//  wr_row    in   $clog2(MATRIX_N)         row index i
//  wr_mat    in   $clog2(NUM_MAT)          matrix index j
//  wr_col    in   $clog2(MATRIX_M)         column index k
//  wr_value  in   VALUE_W                  unsigned element value
//  vblank    in   1                        vertical blanking from vertical_counter
//  bad_addr  out  1                        1-cycle pulse: accepted write had an out-of-range index
//  dirty     out  1                        shadow holds writes not yet committed
//  bcd_flat  out  NUM_MAT*MATRIX_N*MATRIX_M*DIGITS*4   display buffer
// BEHAVIOUR
//  Reset: FSM=IDLE, wr_ready=0 in the reset cycle and 1 from the first clk edge after release.
//   bad_addr=0, dirty=0. Shadow and display buffers are all 4'h0 (4'hA with LZ_BLANK=1, except the
//   LSD, which is 4'h0). Deassertion mid-conversion aborts the conversion; nothing is written.
//  Slot layout: slot s=((i*NUM_MAT+j)*MATRIX_M+k)*DIGITS+l, nibble bcd_flat[4*s+:4].
//   l=0 is the most significant (leftmost) digit.
//  Handshake: transfer when wr_valid&&wr_ready. wr_ready=1 only in IDLE. Inputs are captured on transfer.
//   The caller may change the inputs freely afterwards.
//  FSM:
//   IDLE -> CONV on transfer. Load shift reg = wr_value, BCD acc = 0, bit counter = VALUE_W.
//   CONV: one double-dabble step per cycle (add 3 to each nibble >= 5, then shift left 1).
//    -> WRITE after VALUE_W steps.
//   WRITE: apply saturation/blanking and write the DIGITS nibbles into the shadow. Set dirty. -> IDLE.
//   Latency: transfer at cycle T; shadow updated at edge T+VALUE_W+1; next wr_ready at T+VALUE_W+2.
//  Overflow: if captured value > 10^DIGITS-1, all digits of the slot = 4'h9.
//  Out-of-range i/j/k: transfer accepted, conversion skipped, no write, bad_addr pulses the cycle after
//   transfer, FSM returns to IDLE.
//  Commit: vblank registered (vblank_d). On vblank&&!vblank_d with dirty=1, display <= shadow and
//   dirty <= 0 in one cycle. No commit when dirty=0. Display buffer changes only at commit.
//  Simultaneous WRITE and commit edge: commit copies the pre-write shadow. The new write lands in the
//   shadow and dirty stays 1 for the next frame.
//  vblank held high: one commit per rising edge only.
// STRUCTURE
//  Shared package/header: slot-index function, BLANK_CODE=4'hA, SAT_CODE=4'h9, state encodings.
//  Sub-module bin2bcd_iter (start/done, VALUE_W->DIGITS*4) holds the double-dabble datapath.
//  Top level holds the FSM, address decode, shadow/display buffers and vblank edge detect.
// TESTING
//  1 Reset, write (0,2,1)=12345, pulse vblank -> slot digits 1,2,3,4,5; wr_ready low exactly 17 cycles.
//  2 Write (1,0,0)=7, LZ_BLANK=1 -> nibbles A,A,A,A,7; with LZ_BLANK=0 -> 0,0,0,0,7. Value 0 -> A,A,A,A,0.
//  3 DIGITS=4, write 65535 -> 9,9,9,9; write 9999 -> 9,9,9,9; write 1000 -> 1,0,0,0.
//  4 Write with wr_row=3 -> bad_addr 1-cycle pulse, bcd_flat unchanged after vblank, dirty stays 0.
//  5 Write 42 with WRITE on the vblank rise cycle -> display unchanged that frame, shows 42 after the
//    next vblank rise. vblank held high 100 cycles -> single commit.
//  6 Assert reset_n=0 during CONV of 999 -> buffers return to reset pattern, no write, wr_ready=1 after
//    release.

Source files
------------

// File: rtl/matrix_bcd_loader_pkg.sv
// Shared constants, FSM encoding and slot helpers
// for the matrix BCD loader.
package matrix_bcd_loader_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hA;
  localparam logic [3:0] SAT_CODE   = 4'h9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_WRITE
  } state_t;

  function automatic int unsigned slot_idx(
    input int unsigned i,
    input int unsigned j,
    input int unsigned k,
    input int unsigned l,
    input int unsigned n_mat,
    input int unsigned m_cols,
    input int unsigned digits
  );
    return ((i * n_mat + j) * m_cols + k) * digits + l;
  endfunction

  function automatic longint unsigned pow10(
    input int unsigned n
  );
    longint unsigned r;
    r = 1;
    for (int unsigned q = 0; q < n; q++)
      r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/matrix_bcd_loader_bin2bcd_iter.sv
// Iterative double-dabble converter:
// one add-3/shift step per clock.
module bin2bcd_iter #(
  parameter int VALUE_W = 16,
  parameter int DIGITS  = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [VALUE_W-1:0]    value,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd
);

  localparam int CNT_W = $clog2(VALUE_W + 1);

  logic [VALUE_W-1:0]  shreg_q;
  logic [DIGITS*4-1:0] acc_q;
  logic [DIGITS*4-1:0] adj;
  logic [CNT_W-1:0]    cnt_q;

  always_comb begin
    adj = acc_q;
    for (int d = 0; d < DIGITS; d++)
      if (acc_q[4*d+:4] >= 4'd5)
        adj[4*d+:4] = acc_q[4*d+:4] + 4'd3;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (start) begin
      shreg_q <= value;
      acc_q   <= '0;
      cnt_q   <= CNT_W'(VALUE_W);
    end else if (cnt_q != '0) begin
      acc_q   <= {adj[DIGITS*4-2:0], shreg_q[VALUE_W-1]};
      shreg_q <= {shreg_q[VALUE_W-2:0], 1'b0};
      cnt_q   <= cnt_q - 1'b1;
    end
  end

  // High while the final step executes; bcd is final next cycle.
  assign done = (cnt_q == CNT_W'(1));
  assign bcd  = acc_q;

endmodule

// File: rtl/matrix_bcd_loader.sv
// Matrix element writer: binary -> BCD into a shadow
// buffer, copied to the display buffer on vblank rise.
module matrix_bcd_loader #(
  parameter int MATRIX_N = 3,
  parameter int MATRIX_M = 3,
  parameter int NUM_MAT  = 3,
  parameter int DIGITS   = 5,
  parameter int VALUE_W  = 16,
  parameter int LZ_BLANK = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [$clog2(MATRIX_N)-1:0]   wr_row,
  input  logic [$clog2(NUM_MAT)-1:0]    wr_mat,
  input  logic [$clog2(MATRIX_M)-1:0]   wr_col,
  input  logic [VALUE_W-1:0]            wr_value,
  input  logic                          vblank,
  output logic                          bad_addr,
  output logic                          dirty,
  output logic [NUM_MAT*MATRIX_N*MATRIX_M*DIGITS*4-1:0] bcd_flat
);

  import matrix_bcd_loader_pkg::*;

  localparam int ROW_W = $clog2(MATRIX_N);
  localparam int MAT_W = $clog2(NUM_MAT);
  localparam int COL_W = $clog2(MATRIX_M);
  localparam int SLOTS = NUM_MAT * MATRIX_N * MATRIX_M * DIGITS;
  localparam int BUF_W = SLOTS * 4;

  localparam longint unsigned MAX_VAL = pow10(DIGITS) - 1;

  function automatic logic [BUF_W-1:0] reset_pattern();
    logic [BUF_W-1:0] r;
    r = '0;
    for (int s = 0; s < SLOTS; s++)
      if (LZ_BLANK != 0 && (s % DIGITS) != DIGITS - 1)
        r[4*s+:4] = BLANK_CODE;
    return r;
  endfunction

  localparam logic [BUF_W-1:0] RST_PAT = reset_pattern();

  state_t state_q, state_d;

  logic             ready_q;
  logic             bad_q, bad_d;
  logic             dirty_q;
  logic             vblank_d;
  logic             xfer;
  logic             addr_ok;
  logic             start;
  logic             wr_en;
  logic             conv_done;
  logic             commit;
  logic             ovf_q;
  logic [ROW_W-1:0] row_q;
  logic [MAT_W-1:0] mat_q;
  logic [COL_W-1:0] col_q;
  logic [DIGITS*4-1:0] bcd;
  logic [DIGITS*4-1:0] wr_word;
  logic [3:0]       nib;
  logic             lead;
  int unsigned      base;

  logic [BUF_W-1:0] shadow_q;
  logic [BUF_W-1:0] display_q;

  assign xfer = wr_valid && ready_q;

  assign addr_ok =
    ({1'b0, wr_row} < (ROW_W+1)'(MATRIX_N)) &&
    ({1'b0, wr_mat} < (MAT_W+1)'(NUM_MAT))  &&
    ({1'b0, wr_col} < (COL_W+1)'(MATRIX_M));

  bin2bcd_iter #(
    .VALUE_W (VALUE_W),
    .DIGITS  (DIGITS)
  ) u_conv (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .value   (wr_value),
    .done    (conv_done),
    .bcd     (bcd)
  );

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    wr_en   = 1'b0;
    bad_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          if (addr_ok) begin
            start   = 1'b1;
            state_d = ST_CONV;
          end else begin
            bad_d   = 1'b1;
          end
        end
      end
      ST_CONV: begin
        if (conv_done)
          state_d = ST_WRITE;
      end
      ST_WRITE: begin
        wr_en   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      bad_q   <= 1'b0;
      row_q   <= '0;
      mat_q   <= '0;
      col_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == ST_IDLE);
      bad_q   <= bad_d;
      if (xfer) begin
        row_q <= wr_row;
        mat_q <= wr_mat;
        col_q <= wr_col;
        ovf_q <= 64'(wr_value) > MAX_VAL;
      end
    end
  end

  // Digit l=0 is the MSD; blanking stops at the first nonzero digit.
  always_comb begin
    wr_word = '0;
    nib     = '0;
    lead    = (LZ_BLANK != 0);
    for (int l = 0; l < DIGITS; l++) begin
      nib = bcd[4*(DIGITS-1-l)+:4];
      if (ovf_q) begin
        wr_word[4*l+:4] = SAT_CODE;
      end else if (lead && nib == 4'd0 && l != DIGITS - 1) begin
        wr_word[4*l+:4] = BLANK_CODE;
      end else begin
        wr_word[4*l+:4] = nib;
        lead = 1'b0;
      end
    end
  end

  always_comb
    base = slot_idx(32'(row_q), 32'(mat_q), 32'(col_q), 0,
                    NUM_MAT, MATRIX_M, DIGITS);

  assign commit = vblank && !vblank_d && dirty_q;

  // Commit samples the pre-write shadow; a same-cycle write keeps dirty set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q  <= RST_PAT;
      display_q <= RST_PAT;
      dirty_q   <= 1'b0;
      vblank_d  <= 1'b0;
    end else begin
      vblank_d <= vblank;
      if (commit)
        display_q <= shadow_q;
      if (wr_en) begin
        for (int unsigned l = 0; l < DIGITS; l++)
          shadow_q[4*(base+l)+:4] <= wr_word[4*l+:4];
        dirty_q <= 1'b1;
      end else if (commit) begin
        dirty_q <= 1'b0;
      end
    end
  end

  assign wr_ready = ready_q;
  assign bad_addr = bad_q;
  assign dirty    = dirty_q;
  assign bcd_flat = display_q;

endmodule
